// File: rtl/lcd_bus_driver.sv
// HD44780-style pin timing engine: setup, E pulse, hold, then execution wait per word.
// LCD_LONG_EXEC_EN: decode clear/home for the long wait; otherwise every word waits T_EXEC_LONG.
module lcd_bus_driver #(
    parameter int unsigned T_SETUP     = 4,
    parameter int unsigned T_PW        = 12,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 1850,
    parameter int unsigned T_EXEC_LONG = 76000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [9:0] in_data,
    output logic       in_ready,
    output logic       done,
    output logic       RS,
    output logic       RW,
    output logic       E,
    output logic [7:0] D
);

    localparam int unsigned MAX_A   = (T_SETUP > T_PW) ? T_SETUP : T_PW;
    localparam int unsigned MAX_B   = (MAX_A > T_HOLD) ? MAX_A : T_HOLD;
    localparam int unsigned MAX_C   = (MAX_B > T_EXEC) ? MAX_B : T_EXEC;
    localparam int unsigned MAX_CYC = (MAX_C > T_EXEC_LONG) ? MAX_C : T_EXEC_LONG;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] SETUP_M1 = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] PW_M1    = CW'(T_PW - 1);
    localparam logic [CW-1:0] HOLD_M1  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LONG_M1  = CW'(T_EXEC_LONG - 1);
`ifdef LCD_LONG_EXEC_EN
    localparam logic [CW-1:0] EXEC_M1  = CW'(T_EXEC - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] exec_m1_d;
    logic          rs_q, rw_q, e_q, done_q, ready_q;
    logic [7:0]    d_q;

    // Execution wait is chosen from the latched pins, not the live input.
    always_comb begin
`ifdef LCD_LONG_EXEC_EN
        exec_m1_d = (!rs_q && !rw_q && (d_q inside {8'h01, 8'h02, 8'h03})) ? LONG_M1 : EXEC_M1;
`else
        exec_m1_d = LONG_M1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            e_q     <= 1'b0;
            d_q     <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        rw_q    <= in_data[9];
                        rs_q    <= in_data[8];
                        d_q     <= in_data[7:0];
                        cnt_q   <= SETUP_M1;
                        ready_q <= 1'b0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b1;
                        cnt_q   <= PW_M1;
                        state_q <= PULSE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b0;
                        cnt_q   <= HOLD_M1;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= exec_m1_d;
                        state_q <= EXEC;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    e_q     <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = ready_q;
    assign done     = done_q;
    assign RS       = rs_q;
    assign RW       = rw_q;
    assign E        = e_q;
    assign D        = d_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with shortened timing parameters.
// Expected waits follow LCD_LONG_EXEC_EN exactly as the design is built.
module tb_lcd_bus_driver;

    localparam int unsigned TS = 3;
    localparam int unsigned TP = 5;
    localparam int unsigned TH = 2;
    localparam int unsigned TE = 7;
    localparam int unsigned TL = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [9:0] in_data = '0;
    logic       in_ready, done, RS, RW, E;
    logic [7:0] D;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    lcd_bus_driver #(
        .T_SETUP    (TS),
        .T_PW       (TP),
        .T_HOLD     (TH),
        .T_EXEC     (TE),
        .T_EXEC_LONG(TL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .done    (done),
        .RS      (RS),
        .RW      (RW),
        .E       (E),
        .D       (D)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned exec_x(input logic [9:0] w);
`ifdef LCD_LONG_EXEC_EN
        return (w[9:8] == 2'b00 && w[7:0] >= 8'h01 && w[7:0] <= 8'h03) ? TL : TE;
`else
        return TL;
`endif
    endfunction

    task automatic check_pins(input string tag, input logic [9:0] w);
        check({tag, ".RW"}, 32'(RW), 32'(w[9]));
        check({tag, ".RS"}, 32'(RS), 32'(w[8]));
        check({tag, ".D"}, 32'(D), 32'(w[7:0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".E"}, 32'(E), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        check_pins(tag, 10'h000);
    endtask

    // Accepts w at edge k, then checks every cycle through edge k+N.
    // With hold set, in_valid stays high so the next call accepts at k+N+1.
    task automatic run_word(input logic [9:0] w, input bit hold);
        int unsigned n;
        n = TS + TP + TH + exec_x(w);
        @(negedge clk);
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        in_valid = hold;
        in_data  = 10'h2AA;
        check_pins("accept", w);
        check("accept.E", 32'(E), 32'd0);
        check("accept.done", 32'(done), 32'd0);
        check("accept.in_ready", 32'(in_ready), 32'd0);
        for (int unsigned i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            check("E", 32'(E), 32'(i >= TS && i < TS + TP));
            check("done", 32'(done), 32'(i == n));
            check("in_ready", 32'(in_ready), 32'(i == n));
            check_pins("stable", w);
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            check("done_drop", 32'(done), 32'd0);
            check("idle.in_ready", 32'(in_ready), 32'd1);
            check_pins("after_done", w);
        end
    endtask

    initial begin
        int unsigned pulses;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");

        run_word(10'h038, 1'b0);
        run_word(10'h141, 1'b0);
        run_word(10'h001, 1'b0);
        run_word(10'h000, 1'b0);
        run_word(10'h002, 1'b0);
        run_word(10'h103, 1'b0);
        run_word(10'h203, 1'b0);
        run_word(10'h238, 1'b1);
        run_word(10'h155, 1'b1);
        run_word(10'h003, 1'b0);

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 10'h141;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (TS + 1) @(posedge clk);
        #1;
        check("pre_reset.E", 32'(E), 32'd1);
        #3 rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int unsigned i = 0; i < TS + TP + TH + TL + 5; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("no_done_after_reset", 32'(pulses), 32'd0);
        check_reset_outputs("post_reset");

        run_word(10'h141, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
